// File: rtl/sdiv_hs.sv
// sdiv_hs: pipelined signed fixed-point divider, one restoring step per stage, valid/ready flow control
module sdiv_hs #(
  parameter int WIDTH = 16,
  parameter int SCALE = 8,
  parameter int TAG_WIDTH = 4,
  parameter int ROUND = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     f,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 out_sat,
  output logic                 out_dbz
);
  localparam int D = WIDTH + SCALE;
  localparam logic [WIDTH-1:0] MAXF = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINF = {1'b1, {(WIDTH-1){1'b0}}};
  logic adv;
  logic [D:0] v, sg, dz, nz;
  logic [WIDTH-1:0] rem [D+1];
  logic [WIDTH-1:0] bm [D+1];
  logic [D-1:0] nq [D+1];
  logic [TAG_WIDTH-1:0] tg [D+1];
  logic [WIDTH:0] a_ext, b_ext;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0] t [1:D];
  logic ge [1:D];
  logic [D:0] mag;
  logic pos_sat, neg_sat;
  logic [WIDTH-1:0] f_n;
  assign adv = out_ready | ~out_valid;
  assign in_ready = adv;
  assign a_ext = {a[WIDTH-1], a};
  assign b_ext = {b[WIDTH-1], b};
  assign a_abs = a[WIDTH-1] ? WIDTH'(-a_ext) : a;
  assign b_abs = b[WIDTH-1] ? WIDTH'(-b_ext) : b;
  always_comb begin
    for (int k = 1; k <= D; k++) begin
      t[k] = {rem[k-1], nq[k-1][D-1]};
      ge[k] = t[k] >= {1'b0, bm[k-1]};
    end
  end
  assign mag = {1'b0, nq[D]} + (D+1)'(ROUND != 0 && {rem[D], 1'b0} >= {1'b0, bm[D]});
  assign pos_sat = !sg[D] && mag > (D+1)'(MAXF);
  assign neg_sat = sg[D] && mag > (D+1)'(MINF);
  assign f_n = dz[D] ? (nz[D] ? (sg[D] ? MINF : MAXF) : '0) :
               pos_sat ? MAXF : neg_sat ? MINF : sg[D] ? WIDTH'(-mag) : mag[WIDTH-1:0];
  always_ff @(posedge clk) begin
    if (reset) begin
      v <= '0;
      out_valid <= 1'b0;
      f <= '0;
      out_tag <= '0;
      out_sat <= 1'b0;
      out_dbz <= 1'b0;
    end else if (adv) begin
      v <= {v[D-1:0], in_valid};
      out_valid <= v[D];
      if (v[D]) begin
        f <= f_n;
        out_tag <= tg[D];
        out_sat <= !dz[D] && (pos_sat || neg_sat);
        out_dbz <= dz[D];
      end
    end
    if (adv) begin
      sg <= {sg[D-1:0], a[WIDTH-1] ^ b[WIDTH-1]};
      dz <= {dz[D-1:0], b == '0};
      nz <= {nz[D-1:0], a != '0};
      rem[0] <= '0;
      bm[0] <= b_abs;
      nq[0] <= D'(a_abs) << SCALE;
      tg[0] <= in_tag;
      for (int k = 1; k <= D; k++) begin
        rem[k] <= ge[k] ? WIDTH'(t[k] - {1'b0, bm[k-1]}) : t[k][WIDTH-1:0];
        nq[k] <= {nq[k-1][D-2:0], ge[k]};
        bm[k] <= bm[k-1];
        tg[k] <= tg[k-1];
      end
    end
  end
endmodule

// File: tb/tb_sdiv_hs.sv
// tb_sdiv_hs: scoreboard bench running ROUND=0 and ROUND=1 dividers side by side
module tb_sdiv_hs;
  localparam int D = 24;
  typedef struct packed {
    logic [15:0] f;
    logic [3:0]  tag;
    logic        sat;
    logic        dbz;
    logic        lat;
    logic [31:0] acc;
  } exp_t;
  logic clk = 0, reset = 1, in_valid = 0, out_ready = 1;
  logic [15:0] a = 0, b = 0;
  logic [3:0] in_tag = 0;
  int checks = 0, errors = 0, cyc = 0;
  int pend [2] = '{0, 0};
  logic steady = 1, bp = 0, dir = 0;
  logic [15:0] dir_f0 = 0, dir_f1 = 0;
  logic dir_sat = 0, dir_dbz = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) if (bp) begin
    #1 out_ready = 1'($urandom_range(0, 1));
  end
  function automatic exp_t model(input logic [15:0] x, y, input int rnd);
    exp_t e;
    longint n, d, m, rm;
    bit neg;
    e = '0;
    n = longint'($signed(x));
    d = longint'($signed(y));
    if (d == 0) begin
      e.dbz = 1;
      e.f = n > 0 ? 16'h7fff : n < 0 ? 16'h8000 : 16'h0000;
      return e;
    end
    neg = (n < 0) != (d < 0);
    n = (n < 0 ? -n : n) * 256;
    d = d < 0 ? -d : d;
    m = n / d;
    rm = n % d;
    if (rnd != 0 && 2 * rm >= d) m++;
    if (!neg && m > 32767) begin
      e.sat = 1;
      e.f = 16'h7fff;
    end else if (neg && m > 32768) begin
      e.sat = 1;
      e.f = 16'h8000;
    end else e.f = neg ? 16'(-m) : 16'(m);
    return e;
  endfunction
  for (genvar r = 0; r < 2; r++) begin : g_dut
    logic in_ready, out_valid, out_sat, out_dbz;
    logic [15:0] f;
    logic [3:0] out_tag;
    logic hold = 0, hs = 0, hd = 0;
    logic [15:0] hf = 0;
    logic [3:0] ht = 0;
    exp_t q [$];
    exp_t e;
    sdiv_hs #(.WIDTH(16), .SCALE(8), .TAG_WIDTH(4), .ROUND(r)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
      .f(f), .out_tag(out_tag), .out_sat(out_sat), .out_dbz(out_dbz)
    );
    always @(negedge clk) begin
      if (reset) begin
        q.delete();
        pend[r] = 0;
        hold = 0;
      end else begin
        if (hold) begin
          checks++;
          if (out_valid !== 1'b1 || {f, out_tag, out_sat, out_dbz} !== {hf, ht, hs, hd}) begin
            errors++;
            $display("FAIL hold%0d got v=%b f=%h tag=%h sat=%b dbz=%b want v=1 f=%h tag=%h sat=%b dbz=%b",
                     r, out_valid, f, out_tag, out_sat, out_dbz, hf, ht, hs, hd);
          end
        end
        if (out_valid && out_ready) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL spurious%0d got f=%h tag=%h want no output", r, f, out_tag);
          end else begin
            e = q.pop_front();
            pend[r]--;
            if ({f, out_tag, out_sat, out_dbz} !== {e.f, e.tag, e.sat, e.dbz}) begin
              errors++;
              $display("FAIL result%0d got f=%h tag=%h sat=%b dbz=%b want f=%h tag=%h sat=%b dbz=%b",
                       r, f, out_tag, out_sat, out_dbz, e.f, e.tag, e.sat, e.dbz);
            end
            if (e.lat) begin
              checks++;
              if (cyc - int'(e.acc) != D + 2) begin
                errors++;
                $display("FAIL latency%0d got %0d want %0d", r, cyc - int'(e.acc), D + 2);
              end
            end
          end
        end
        if (in_valid && in_ready) begin
          e = model(a, b, r);
          if (dir) begin
            e.f = (r == 0) ? dir_f0 : dir_f1;
            e.sat = dir_sat;
            e.dbz = dir_dbz;
          end
          e.tag = in_tag;
          e.lat = steady;
          e.acc = 32'(cyc);
          q.push_back(e);
          pend[r]++;
        end
        hold = out_valid && !out_ready;
        hf = f;
        ht = out_tag;
        hs = out_sat;
        hd = out_dbz;
      end
    end
  end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", n, act, exp);
    end
  endtask
  task automatic send(input logic [15:0] x, y, input logic [3:0] tg);
    int n = 0;
    a = x;
    b = y;
    in_tag = tg;
    in_valid = 1;
    @(negedge clk);
    while (!g_dut[0].in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!g_dut[0].in_ready) begin
      checks++;
      errors++;
      $display("FAIL handshake got in_ready=0 want 1");
    end
    @(posedge clk);
    #1 in_valid = 0;
  endtask
  task automatic dsend(input logic [15:0] x, y, input logic [3:0] tg,
                       input logic [15:0] f0, f1, input logic s, z);
    dir = 1;
    dir_f0 = f0;
    dir_f1 = f1;
    dir_sat = s;
    dir_dbz = z;
    send(x, y, tg);
    dir = 0;
  endtask
  task automatic rsend(input logic [3:0] tg);
    int k;
    logic [15:0] y;
    k = $urandom_range(0, 7);
    y = k == 0 ? 16'h0000 : k < 3 ? 16'($urandom_range(1, 255)) : 16'($urandom);
    if (k == 3) y = -y;
    send(16'($urandom), y, tg);
  endtask
  task automatic drain();
    int n = 0;
    while ((pend[0] != 0 || pend[1] != 0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (pend[0] != 0 || pend[1] != 0) begin
      errors++;
      $display("FAIL drain got pending %0d/%0d want 0/0", pend[0], pend[1]);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic idle_chk(input string s);
    chk({s, "_valid0"}, 32'(g_dut[0].out_valid), 0);
    chk({s, "_valid1"}, 32'(g_dut[1].out_valid), 0);
    chk({s, "_ready0"}, 32'(g_dut[0].in_ready), 1);
    chk({s, "_ready1"}, 32'(g_dut[1].in_ready), 1);
  endtask
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    idle_chk("rst");
    chk("rst_f0", 32'(g_dut[0].f), 0);
    chk("rst_f1", 32'(g_dut[1].f), 0);
    chk("rst_flags0", 32'({g_dut[0].out_tag, g_dut[0].out_sat, g_dut[0].out_dbz}), 0);
    chk("rst_flags1", 32'({g_dut[1].out_tag, g_dut[1].out_sat, g_dut[1].out_dbz}), 0);
    @(posedge clk);
    #1 reset = 0;
    dsend(16'h0300, 16'h0200, 4'd1, 16'h0180, 16'h0180, 0, 0);
    dsend(16'hFD00, 16'h0200, 4'd2, 16'hFE80, 16'hFE80, 0, 0);
    drain();
    dsend(16'h0002, 16'h0300, 4'd3, 16'h0000, 16'h0001, 0, 0);
    dsend(16'hFFFE, 16'h0300, 4'd4, 16'h0000, 16'hFFFF, 0, 0);
    dsend(16'h7FFF, 16'h0001, 4'd5, 16'h7FFF, 16'h7FFF, 1, 0);
    dsend(16'h8000, 16'hFF00, 4'd6, 16'h7FFF, 16'h7FFF, 1, 0);
    dsend(16'h8000, 16'h0100, 4'd7, 16'h8000, 16'h8000, 0, 0);
    dsend(16'h0100, 16'h0000, 4'd8, 16'h7FFF, 16'h7FFF, 0, 1);
    dsend(16'hFF00, 16'h0000, 4'd9, 16'h8000, 16'h8000, 0, 1);
    dsend(16'h0000, 16'h0000, 4'd10, 16'h0000, 16'h0000, 0, 1);
    drain();
    for (int i = 0; i < 20; i++) rsend(4'(i));
    drain();
    steady = 0;
    bp = 1;
    for (int i = 0; i < 40; i++) begin
      rsend(4'(i));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    bp = 0;
    @(posedge clk);
    #1 out_ready = 1;
    drain();
    steady = 1;
    for (int i = 0; i < 5; i++) rsend(4'(i));
    reset = 1;
    in_valid = 1;
    a = 16'h1234;
    b = 16'h0100;
    in_tag = 4'hF;
    @(posedge clk);
    #1 reset = 0;
    in_valid = 0;
    @(negedge clk);
    idle_chk("midrst");
    for (int i = 5; i < 10; i++) rsend(4'(i));
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sdiv_hs.md
SDIV_HS -- requirements
Module: sdiv_hs

Interface
REQ-001 Parameter WIDTH, default 16, operand and result width in bits, two's complement; SHALL be 4 to 32.
REQ-002 Parameter SCALE, default 8, number of fraction bits; SHALL be 0 to WIDTH-1.
REQ-003 Parameter TAG_WIDTH, default 4, width of the sideband tag; SHALL be at least 1.
REQ-004 Parameter ROUND, default 0: 0 truncates toward zero, 1 rounds half away from zero.
REQ-005 Port clk, input, 1: the only clock; all state SHALL update on its rising edge.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port in_valid, input, 1: a, b and in_tag are presented.
REQ-008 Port in_ready, output, 1: the block accepts input this cycle.
REQ-009 Port a, input, WIDTH: dividend, fixed point with SCALE fraction bits.
REQ-010 Port b, input, WIDTH: divisor, same format as a.
REQ-011 Port in_tag, input, TAG_WIDTH: opaque tag carried with the operands.
REQ-012 Port out_valid, output, 1: result fields are valid.
REQ-013 Port out_ready, input, 1: the downstream consumer accepts the result.
REQ-014 Port f, output, WIDTH: quotient a/b, same format as a.
REQ-015 Port out_tag, output, TAG_WIDTH: the in_tag of the same transaction.
REQ-016 Port out_sat, output, 1: the result was clamped to the WIDTH range.
REQ-017 Port out_dbz, output, 1: the divisor was zero.

Function
REQ-018 Signal adv SHALL equal (out_ready OR NOT out_valid).
- in_ready SHALL equal adv.
- All pipeline stages SHALL shift together only when adv=1; otherwise every stage holds.
- A stall SHALL NOT collapse bubbles.
REQ-019 A transfer SHALL occur on a cycle with in_valid=1 and in_ready=1.
- Each stage SHALL carry a valid bit; invalid slots SHALL propagate as bubbles.
REQ-020 Pipeline depth and latency: D = WIDTH+SCALE.
- Stage 0 (input): register |a|, |b|, sign = a[MSB] XOR b[MSB], the dbz flag and the tag.
- Stages 1..D: restoring division, one quotient bit per stage, MSB first.
  - Dividend magnitude: |a| shifted left by SCALE, D bits wide.
  - Divisor magnitude: |b|, zero-extended.
- Final stage: apply rounding, sign, saturation and the dbz override.
REQ-021 With no stall, out_valid SHALL rise exactly D+2 cycles after the transfer cycle.
- Full throughput: one result per cycle.
- Results SHALL leave in acceptance order.
REQ-022 Absolute values SHALL be computed at WIDTH+1 bits, so |-2^(WIDTH-1)| is exact.
REQ-023 Rounding, when ROUND=1: if 2*remainder >= |b|, the magnitude SHALL be incremented by one before sign application.
REQ-024 Saturation limits: MAX = 2^(WIDTH-1)-1 and MIN = -2^(WIDTH-1).
- Positive result with magnitude > MAX: f SHALL be MAX and out_sat SHALL be 1.
- Negative result with magnitude > 2^(WIDTH-1): f SHALL be MIN and out_sat SHALL be 1.
- Otherwise out_sat SHALL be 0.
REQ-025 Divide by zero (b=0): out_dbz SHALL be 1 and out_sat SHALL be 0.
- f SHALL be MAX if a>0, MIN if a<0, and 0 if a=0.
- The divider datapath result SHALL be ignored.
REQ-026 A zero quotient with negative sign SHALL produce f=0; negative zero SHALL NOT be emitted.
REQ-027 f, out_tag, out_sat and out_dbz SHALL hold stable while out_valid=1 and out_ready=0.

Reset
REQ-028 While reset=1:
- All stage valid bits and out_valid SHALL be 0 on the next edge.
- f, out_tag, out_sat and out_dbz SHALL be 0.
- in_ready SHALL be 1.
REQ-029 Reset asserted mid-operation SHALL discard every in-flight transaction; none SHALL appear after reset deasserts.
REQ-030 Inputs presented during a reset cycle SHALL NOT be accepted.

Verification (WIDTH=16, SCALE=8 unless noted)
REQ-031 Basic division, one per cycle, out_ready=1:
- a=0x0300, b=0x0200, tag=1 -> f=0x0180, tag=1, flags 0.
- a=0xFD00, b=0x0200, tag=2 -> f=0xFE80, tag=2, flags 0.
- First result exactly 26 cycles after acceptance; second result on the next cycle.
REQ-032 Rounding, a=0x0002, b=0x0300:
- ROUND=0 -> f=0x0000.
- ROUND=1 -> f=0x0001.
- Also a=0xFFFE, b=0x0300 with ROUND=1 -> f=0xFFFF.
REQ-033 Saturation:
- a=0x7FFF, b=0x0001 -> f=0x7FFF, out_sat=1.
- a=0x8000, b=0xFF00 -> f=0x7FFF, out_sat=1.
- a=0x8000, b=0x0100 -> f=0x8000, out_sat=0.
REQ-034 Divide by zero, b=0x0000:
- a=0x0100 -> f=0x7FFF, out_dbz=1.
- a=0xFF00 -> f=0x8000, out_dbz=1.
- a=0x0000 -> f=0x0000, out_dbz=1.
REQ-035 Backpressure:
- Stream 40 random transfers while out_ready toggles randomly.
- Check: no loss, no duplication, order preserved via tags, and outputs stable whenever out_valid=1 and out_ready=0.
REQ-036 Reset mid-flight:
- Accept 10 transfers, assert reset for 1 cycle at cycle 5.
- Required: out_valid stays 0 until a post-reset transfer completes D+2 cycles later.
